// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with big-endian byte lanes.
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module data_cache #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SET_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [1:0]               cpu_size,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     cpu_ready,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [3:0]               mem_be,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
`endif
);

  localparam int TAG_W = ADDRESS_WIDTH - SET_WIDTH - 2;
  localparam int LINES = 2 ** SET_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Big-endian lane select: offset 0 is bits [31:24], result zero-extended.
  function automatic logic [31:0] load_lane(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] offset);
    logic [31:0] result;
    result = word;
    case (size)
      2'b00: begin
        case (offset)
          2'b00:   result = {24'h000000, word[31:24]};
          2'b01:   result = {24'h000000, word[23:16]};
          2'b10:   result = {24'h000000, word[15:8]};
          default: result = {24'h000000, word[7:0]};
        endcase
      end
      2'b01: begin
        if (offset[1]) begin
          result = {16'h0000, word[15:0]};
        end else begin
          result = {16'h0000, word[31:16]};
        end
      end
      default: result = word;
    endcase
    return result;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] be;
    be = 4'b1111;
    case (size)
      2'b00: begin
        case (offset)
          2'b00:   be = 4'b1000;
          2'b01:   be = 4'b0100;
          2'b10:   be = 4'b0010;
          default: be = 4'b0001;
        endcase
      end
      2'b01: begin
        if (offset[1]) begin
          be = 4'b0011;
        end else begin
          be = 4'b1100;
        end
      end
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicating the store value puts it in whichever lane the byte enables pick.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      2'b00:   lanes = {4{data[7:0]}};
      2'b01:   lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word, input logic [31:0] new_word,
                                              input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_word & ~mask) | (new_word & mask);
  endfunction

  state_t                   state_r;
  state_t                   state_s;
  logic [LINES-1:0]         valid_r;
  logic [TAG_W-1:0]         tag_mem_r  [LINES];
  logic [31:0]              data_mem_r [LINES];
  logic [ADDRESS_WIDTH-1:0] req_addr_r;
  logic [1:0]               req_size_r;
  logic [31:0]              cpu_rdata_r;
  logic                     cpu_ready_r;
  logic                     mem_req_r;
  logic                     mem_we_r;
  logic [ADDRESS_WIDTH-1:0] mem_addr_r;
  logic [31:0]              mem_wdata_r;
  logic [3:0]               mem_be_r;

  logic [ADDRESS_WIDTH-1:0] addr_s;
  logic [SET_WIDTH-1:0]     idx_s;
  logic [TAG_W-1:0]         tag_s;
  logic                     hit_s;
  logic                     leave_idle_s;
  logic                     refill_done_s;
  logic                     write_done_s;

  // Lookup uses the live request in IDLE and the latched one afterwards.
  assign addr_s        = (state_r == IDLE) ? cpu_addr : req_addr_r;
  assign idx_s         = addr_s[SET_WIDTH+1:2];
  assign tag_s         = addr_s[ADDRESS_WIDTH-1:SET_WIDTH+2];
  assign hit_s         = valid_r[idx_s] && (tag_mem_r[idx_s] == tag_s);
  assign leave_idle_s  = (state_r == IDLE) && cpu_req;
  assign refill_done_s = (state_r == REFILL) && mem_ack;
  assign write_done_s  = (state_r == WRITE) && mem_ack;

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            state_s = WRITE;
          end else if (hit_s) begin
            state_s = DONE;
          end else begin
            state_s = REFILL;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REFILL: begin
        if (mem_ack) begin
          state_s = DONE;
        end else begin
          state_s = REFILL;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          state_s = DONE;
        end else begin
          state_s = WRITE;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, request latch, valid bits and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      valid_r     <= '0;
      req_addr_r  <= '0;
      req_size_r  <= 2'b00;
      cpu_rdata_r <= 32'h0000_0000;
      cpu_ready_r <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 32'h0000_0000;
      mem_be_r    <= 4'b0000;
    end else begin
      state_r     <= state_s;
      cpu_ready_r <= (state_s == DONE);
      mem_req_r   <= (state_s == REFILL) || (state_s == WRITE);
      if (leave_idle_s) begin
        req_addr_r  <= cpu_addr;
        req_size_r  <= cpu_size;
        mem_we_r    <= cpu_we;
        mem_addr_r  <= {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
        mem_be_r    <= cpu_we ? store_be(cpu_size, cpu_addr[1:0]) : 4'b1111;
        mem_wdata_r <= cpu_we ? store_lanes(cpu_size, cpu_wdata) : 32'h0000_0000;
      end
      if (leave_idle_s && !cpu_we && hit_s) begin
        cpu_rdata_r <= load_lane(data_mem_r[idx_s], cpu_size, cpu_addr[1:0]);
      end else if (refill_done_s) begin
        cpu_rdata_r <= load_lane(mem_rdata, req_size_r, req_addr_r[1:0]);
      end
      if (refill_done_s) begin
        valid_r[idx_s] <= 1'b1;
      end
    end
  end

  // Tag/data arrays: refill replaces the line, a store hit merges its lanes
  always_ff @(posedge clk) begin
    if (refill_done_s) begin
      tag_mem_r[idx_s]  <= tag_s;
      data_mem_r[idx_s] <= mem_rdata;
    end else if (write_done_s && hit_s) begin
      data_mem_r[idx_s] <= merge_lanes(data_mem_r[idx_s], mem_wdata_r, mem_be_r);
    end
  end

  assign cpu_rdata = cpu_rdata_r;
  assign cpu_ready = cpu_ready_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_be    = mem_be_r;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_r;
  logic [31:0] miss_count_r;

  // Saturating hit/miss counters, classified when the access leaves IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_r  <= 32'h0000_0000;
      miss_count_r <= 32'h0000_0000;
    end else if (leave_idle_s) begin
      if (hit_s) begin
        if (hit_count_r != 32'hFFFF_FFFF) begin
          hit_count_r <= hit_count_r + 32'd1;
        end
      end else begin
        if (miss_count_r != 32'hFFFF_FFFF) begin
          miss_count_r <= miss_count_r + 32'd1;
        end
      end
    end
  end

  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: directed accesses push expected CPU and memory
// transactions; a CPU monitor and a memory responder pop and compare them.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        abort;
  } mem_txn_t;

  typedef struct {
    logic        is_load;
    logic [31:0] rdata;
  } cpu_exp_t;

  mem_txn_t mem_q[$];
  cpu_exp_t cpu_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int mem_cnt  = 0;

  data_cache dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_size  (cpu_size),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic expect_mem(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input logic [31:0] rdata, input logic abort);
    mem_q.push_back('{we: we, addr: addr, be: be, wdata: wdata, rdata: rdata, abort: abort});
  endtask

  // Issues one access at a negedge and returns one cycle after cpu_ready.
  task automatic cpu_access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata,
                            input logic exp_hit);
    int lat;
    int mem_before;
    mem_before = mem_cnt;
    cpu_q.push_back('{is_load: !we, rdata: exp_rdata});
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_size  = size;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        // Garbage on the inputs once the request is latched must not matter.
        cpu_we    = ~we;
        cpu_size  = ~size;
        cpu_addr  = ~addr;
        cpu_wdata = ~wdata;
      end
    end while (!cpu_ready && lat < 50);
    if (!cpu_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: no cpu_ready for addr 0x%08h within %0d cycles", addr, lat);
      cpu_q.delete();
    end
    cpu_req = 1'b0;
    if (exp_hit) begin
      chk("hit_latency", 32'(lat), 32'd1);
      chk("hit_no_mem_req", 32'(mem_cnt), 32'(mem_before));
    end
    @(negedge clk);
    chk("ready_pulse", 32'(cpu_ready), 32'd0);
  endtask

  // CPU-side monitor
  initial begin
    cpu_exp_t e;
    forever begin
      @(negedge clk);
      if (cpu_ready) begin
        if (cpu_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ready: cpu_ready=1 with no access outstanding");
        end else begin
          e = cpu_q.pop_front();
          if (e.is_load) chk("load_rdata", cpu_rdata, e.rdata);
        end
      end
    end
  end

  // Memory responder: checks each request, acks after 3 cycles unless aborting
  initial begin
    mem_txn_t    t;
    logic        known;
    logic [31:0] a0;
    logic [31:0] w0;
    logic [3:0]  b0;
    int          k;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        mem_cnt++;
        known = (mem_q.size() != 0);
        if (!known) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_mem_req: addr 0x%08h we %0b", mem_addr, mem_we);
          t = '{we: 1'b0, addr: 32'h0, be: 4'h0, wdata: 32'h0, rdata: 32'h0, abort: 1'b0};
        end else begin
          t = mem_q.pop_front();
          chk("mem_we", 32'(mem_we), 32'(t.we));
          chk("mem_addr", mem_addr, t.addr);
          chk("mem_be", 32'(mem_be), 32'(t.be));
          if (t.we) chk("mem_wdata_lanes", mem_wdata & be_mask(t.be), t.wdata & be_mask(t.be));
        end
        a0 = mem_addr;
        w0 = mem_wdata;
        b0 = mem_be;
        if (t.abort) begin
          k = 0;
          while (mem_req && k < 20) begin
            @(negedge clk);
            k++;
          end
          chk("abort_mem_req_low", 32'(mem_req), 32'd0);
        end else begin
          repeat (2) begin
            @(negedge clk);
            chk("mem_req_held", 32'(mem_req), 32'd1);
            chk("mem_addr_stable", mem_addr, a0);
            chk("mem_wdata_stable", mem_wdata, w0);
            chk("mem_be_stable", 32'(mem_be), 32'(b0));
          end
          mem_ack   = 1'b1;
          mem_rdata = t.rdata;
          @(negedge clk);
          mem_ack   = 1'b0;
          mem_rdata = 32'h0;
          chk("mem_req_drop", 32'(mem_req), 32'd0);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_size  = 2'b00;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Cold miss, then hits with every size and offset
    expect_mem(1'b0, 32'h0001_0000, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0);
    cpu_access(1'b0, 2'b10, 32'h0001_0000, 32'h0, 32'hDEAD_BEEF, 1'b0);
    cpu_access(1'b0, 2'b10, 32'h0001_0000, 32'h0, 32'hDEAD_BEEF, 1'b1);
    cpu_access(1'b0, 2'b00, 32'h0001_0001, 32'h0, 32'h0000_00AD, 1'b1);
    cpu_access(1'b0, 2'b01, 32'h0001_0002, 32'h0, 32'h0000_BEEF, 1'b1);
    cpu_access(1'b0, 2'b00, 32'h0001_0000, 32'h0, 32'h0000_00DE, 1'b1);
    cpu_access(1'b0, 2'b01, 32'h0001_0001, 32'h0, 32'h0000_DEAD, 1'b1);
    cpu_access(1'b0, 2'b11, 32'h0001_0003, 32'h0, 32'hDEAD_BEEF, 1'b1);

    // Store hits: lanes, enables, merge, immediate reload
    expect_mem(1'b1, 32'h0001_0000, 4'b0001, 32'h0000_0055, 32'h0, 1'b0);
    cpu_access(1'b1, 2'b00, 32'h0001_0003, 32'hABCD_EF55, 32'h0, 1'b0);
    cpu_access(1'b0, 2'b10, 32'h0001_0000, 32'h0, 32'hDEAD_BE55, 1'b1);
    expect_mem(1'b1, 32'h0001_0000, 4'b1100, 32'h1234_0000, 32'h0, 1'b0);
    cpu_access(1'b1, 2'b01, 32'h0001_0000, 32'h0000_1234, 32'h0, 1'b0);
    expect_mem(1'b1, 32'h0001_0000, 4'b0011, 32'h0000_CAFE, 32'h0, 1'b0);
    cpu_access(1'b1, 2'b01, 32'h0001_0003, 32'h5555_CAFE, 32'h0, 1'b0);
    expect_mem(1'b1, 32'h0001_0000, 4'b0010, 32'h0000_7700, 32'h0, 1'b0);
    cpu_access(1'b1, 2'b00, 32'h0001_0002, 32'h0000_0077, 32'h0, 1'b0);
    cpu_access(1'b0, 2'b10, 32'h0001_0000, 32'h0, 32'h1234_77FE, 1'b1);
    cpu_access(1'b0, 2'b00, 32'h0001_0002, 32'h0, 32'h0000_0077, 1'b1);

    // Store miss leaves the cache alone; the following load misses
    expect_mem(1'b1, 32'h0001_0400, 4'hF, 32'h0A0B_0C0D, 32'h0, 1'b0);
    cpu_access(1'b1, 2'b10, 32'h0001_0400, 32'h0A0B_0C0D, 32'h0, 1'b0);
    cpu_access(1'b0, 2'b10, 32'h0001_0000, 32'h0, 32'h1234_77FE, 1'b1);
    expect_mem(1'b0, 32'h0001_0400, 4'hF, 32'h0, 32'h0A0B_0C0D, 1'b0);
    cpu_access(1'b0, 2'b10, 32'h0001_0400, 32'h0, 32'h0A0B_0C0D, 1'b0);
    cpu_access(1'b0, 2'b10, 32'h0001_0400, 32'h0, 32'h0A0B_0C0D, 1'b1);

    // Conflict on index 0
    expect_mem(1'b0, 32'h0001_0000, 4'hF, 32'h0, 32'h1122_3344, 1'b0);
    cpu_access(1'b0, 2'b10, 32'h0001_0000, 32'h0, 32'h1122_3344, 1'b0);
    expect_mem(1'b0, 32'h0001_0400, 4'hF, 32'h0, 32'h5566_7788, 1'b0);
    cpu_access(1'b0, 2'b10, 32'h0001_0400, 32'h0, 32'h5566_7788, 1'b0);
    expect_mem(1'b0, 32'h0001_0000, 4'hF, 32'h0, 32'h99AA_BBCC, 1'b0);
    cpu_access(1'b0, 2'b10, 32'h0001_0000, 32'h0, 32'h99AA_BBCC, 1'b0);

    // Byte load miss returns the lane from the refill word
    expect_mem(1'b0, 32'h0003_0000, 4'hF, 32'h0, 32'hA1B2_C3D4, 1'b0);
    cpu_access(1'b0, 2'b00, 32'h0003_0001, 32'h0, 32'h0000_00B2, 1'b0);

    // Reset in the middle of a refill
    expect_mem(1'b0, 32'h0002_0010, 4'hF, 32'h0, 32'h0, 1'b1);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_size = 2'b10;
    cpu_addr = 32'h0002_0010;
    repeat (2) @(negedge clk);
    chk("refill_mem_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("abort_cpu_rdata", cpu_rdata, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    expect_mem(1'b0, 32'h0002_0010, 4'hF, 32'h0, 32'hFEED_F00D, 1'b0);
    cpu_access(1'b0, 2'b10, 32'h0002_0010, 32'h0, 32'hFEED_F00D, 1'b0);
    expect_mem(1'b0, 32'h0003_0000, 4'hF, 32'h0, 32'hA1B2_C3D4, 1'b0);
    cpu_access(1'b0, 2'b01, 32'h0003_0002, 32'h0, 32'h0000_C3D4, 1'b0);

    repeat (3) @(negedge clk);
    chk("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
    chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
